ram_io_responder: RTL and testbench

Byte-wide memory responder at the far end of the memory IO controller's RAM port. Holds the unified instruction/data RAM and a memory-mapped I/O window (byte console in/out, status, halt). Serves one byte per cycle with a fixed one-cycle registered read latency, matching what the controller expects. Host-side valid/ready byte streams feed the console.

---
 rtl/ram_io_responder.sv | 184 ++++++++++++++++++
 tb/tb_ram_io_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_io_responder (+ ram_io_fifo)
//  Purpose  : Byte-wide RAM plus console/status/halt IO window with a
//             one-cycle registered read.
//  Revision : 1.0
// ============================================================================

module ram_io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_dat,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [7:0]         r_buf [0:DEPTH-1];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_buf[r_wr_ptr] <= i_push_dat;
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign o_head  = o_empty ? 8'h00 : r_buf[r_rd_ptr];
endmodule

module ram_io_responder #(
    parameter int    ADDR_W     = 18,
    parameter int    MEM_ADR_W  = 17,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = "test.data"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              rwen_i,
    input  logic [7:0]        dat_i,
    output logic [7:0]        dat_o,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_dat_i,
    output logic              rx_ready_o,
    output logic              tx_valid_o,
    output logic [7:0]        tx_dat_o,
    input  logic              tx_ready_i,
    output logic              io_full_o,
    output logic              halt_o,
    output logic              ovf_o
);
    localparam logic [3:0] c_off_con  = 4'h0;
    localparam logic [3:0] c_off_halt = 4'h4;
    localparam logic [3:0] c_off_stat = 4'h8;

    logic [7:0] r_mem [0:(2**MEM_ADR_W)-1];

    logic [7:0]        r_dat;
    logic              r_halt;
    logic              r_ovf;
    logic              r_trk_vld;
    logic [ADDR_W-1:0] r_trk_adr;
    logic              r_trk_rwen;

    logic [MEM_ADR_W-1:0] w_idx;
    logic [3:0]           w_off;
    logic                 w_io_sel;
    logic                 w_con;
    logic                 w_dup;
    logic                 w_con_rd;
    logic                 w_con_wr;
    logic                 w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
    logic                 w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
    logic [7:0]           w_rx_head, w_tx_head;
    logic                 w_ovf_set;

    assign w_idx    = adr_i[MEM_ADR_W-1:0];
    assign w_off    = adr_i[3:0];
    assign w_io_sel = (adr_i[ADDR_W-1:ADDR_W-2] == 2'b11);
    assign w_con    = w_io_sel && (w_off == c_off_con);

    // The controller re-presents the same address while idle; a console access
    // only acts once until some other enabled access intervenes.
    assign w_dup    = r_trk_vld && (r_trk_adr == adr_i) && (r_trk_rwen == rwen_i);
    assign w_con_rd = en && w_con && !rwen_i && !w_dup;
    assign w_con_wr = en && w_con &&  rwen_i && !w_dup;

    assign w_rx_push = rx_valid_i && rx_ready_o;
    assign w_rx_pop  = w_con_rd && !w_rx_empty;
    assign w_tx_pop  = tx_valid_o && tx_ready_i;
    // A full tx FIFO being drained this cycle still has room for the write.
    assign w_tx_push = w_con_wr && (!w_tx_full || w_tx_pop);
    assign w_ovf_set = w_con_wr && w_tx_full && !w_tx_pop;

    ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rx_push),
        .i_push_dat (rx_dat_i),
        .i_pop      (w_rx_pop),
        .o_head     (w_rx_head),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full)
    );

    ram_io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_tx_push),
        .i_push_dat (dat_i),
        .i_pop      (w_tx_pop),
        .o_head     (w_tx_head),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full)
    );

    always_ff @(posedge clk) begin
        if (en && rwen_i && !w_io_sel) r_mem[w_idx] <= dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat      <= 8'h00;
            r_halt     <= 1'b0;
            r_ovf      <= 1'b0;
            r_trk_vld  <= 1'b0;
            r_trk_adr  <= '0;
            r_trk_rwen <= 1'b0;
        end else if (en) begin
            r_trk_vld  <= w_con;
            r_trk_adr  <= adr_i;
            r_trk_rwen <= rwen_i;
            if (!rwen_i) begin
                if (!w_io_sel) begin
                    r_dat <= r_mem[w_idx];
                end else begin
                    case (w_off)
                        // A repeated console read keeps the byte it popped.
                        c_off_con:  if (!w_dup) r_dat <= w_rx_empty ? 8'h00 : w_rx_head;
                        c_off_stat: r_dat <= {6'b0, w_tx_full, !w_rx_empty};
                        default:    r_dat <= 8'h00;
                    endcase
                end
            end else if (w_io_sel && (w_off == c_off_halt)) begin
                r_halt <= 1'b1;
            end
            if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    assign dat_o      = r_dat;
    assign halt_o     = r_halt;
    assign ovf_o      = r_ovf;
    assign rx_ready_o = !w_rx_full;
    assign tx_valid_o = !w_tx_empty;
    assign tx_dat_o   = w_tx_head;
    assign io_full_o  = w_tx_full;
endmodule

`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_io_responder
//  Purpose  : Scoreboard bench for ram_io_responder with directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_ram_io_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [17:0] adr_i = '0;
    logic        rwen_i = 1'b0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_dat_i = '0;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_dat_o;
    logic        tx_ready_i = 1'b0;
    logic        io_full_o;
    logic        halt_o;
    logic        ovf_o;

    ram_io_responder dut (
        .clk(clk), .rst(rst), .en(en), .adr_i(adr_i), .rwen_i(rwen_i),
        .dat_i(dat_i), .dat_o(dat_o), .rx_valid_i(rx_valid_i),
        .rx_dat_i(rx_dat_i), .rx_ready_o(rx_ready_o), .tx_valid_o(tx_valid_o),
        .tx_dat_o(tx_dat_o), .tx_ready_i(tx_ready_i), .io_full_o(io_full_o),
        .halt_o(halt_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef enum int {S_DAT, S_TXV, S_TXD, S_RXR, S_FULL, S_HALT, S_OVF} sig_e;
    typedef struct {
        int         due;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input sig_e s);
        case (s)
            S_DAT:   return dat_o;
            S_TXV:   return {7'b0, tx_valid_o};
            S_TXD:   return tx_dat_o;
            S_RXR:   return {7'b0, rx_ready_o};
            S_FULL:  return {7'b0, io_full_o};
            S_HALT:  return {7'b0, halt_o};
            default: return {7'b0, ovf_o};
        endcase
    endfunction

    // Monitor: pops due expectations and checks every tx handshake in order.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        logic [7:0] want;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e   = exp_q.pop_front();
            act = sample(e.sig);
            total++;
            if (e.due != cyc || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %02h want %02h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
        if (tx_valid_o && tx_ready_i) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected: got %02h want no byte", tx_dat_o);
            end else begin
                want = tx_q.pop_front();
                if (tx_dat_o !== want) begin
                    bad++;
                    $display("FAIL tx_byte: got %02h want %02h", tx_dat_o, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input sig_e s, input logic [7:0] v, input string n);
        exp_t e;
        e.due = cyc; e.sig = s; e.val = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic acc(input logic [17:0] a, input logic w, input logic [7:0] d);
        en = 1'b1; adr_i = a; rwen_i = w; dat_i = d;
        step();
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) step();
    endtask

    task automatic host_rx(input logic [7:0] d);
        rx_valid_i = 1'b1; rx_dat_i = d;
        step();
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk(S_DAT, 8'h00, "rst_dat"); chk(S_RXR, 8'h01, "rst_rx_ready");
        chk(S_TXV, 8'h00, "rst_tx_valid"); chk(S_TXD, 8'h00, "rst_tx_dat");
        chk(S_FULL, 8'h00, "rst_io_full"); chk(S_HALT, 8'h00, "rst_halt");
        chk(S_OVF, 8'h00, "rst_ovf");

        // RAM round trip
        acc(18'h00000, 1'b1, 8'h5A);
        acc(18'h00010, 1'b1, 8'hA5);
        chk(S_DAT, 8'h00, "ram_wr_holds");
        acc(18'h00010, 1'b0, 8'h00);
        chk(S_DAT, 8'hA5, "ram_rd_10");
        acc(18'h00011, 1'b1, 8'h3C);
        acc(18'h00011, 1'b0, 8'h00);
        chk(S_DAT, 8'h3C, "ram_rd_11");
        acc(18'h00000, 1'b0, 8'h00);
        chk(S_DAT, 8'h5A, "ram_rd_00");
        idle(1);

        // Console out
        acc(18'h30000, 1'b1, 8'h41); tx_q.push_back(8'h41);
        acc(18'h3000C, 1'b0, 8'h00);
        acc(18'h30000, 1'b1, 8'h42); tx_q.push_back(8'h42);
        idle(1);
        chk(S_TXV, 8'h01, "con_tx_valid"); chk(S_TXD, 8'h41, "con_tx_head");
        tx_ready_i = 1'b1;
        step(); step();
        tx_ready_i = 1'b0;
        chk(S_TXV, 8'h00, "con_tx_drained");

        // De-duplication
        host_rx(8'h11); host_rx(8'h22);
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h11, "dedup_rd1");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h11, "dedup_rd2");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h11, "dedup_rd3");
        acc(18'h00000, 1'b0, 8'h00); chk(S_DAT, 8'h5A, "dedup_ram");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h22, "dedup_second");
        acc(18'h30008, 1'b0, 8'h00); chk(S_DAT, 8'h00, "dedup_status_empty");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h00, "rd_empty_zero");

        // Overflow
        for (int k = 0; k < 8; k++) begin
            acc(18'h30000, 1'b1, 8'h80 + 8'(k)); tx_q.push_back(8'h80 + 8'(k));
            acc(18'h3000C, 1'b0, 8'h00);
        end
        chk(S_FULL, 8'h01, "ovf_full"); chk(S_OVF, 8'h00, "ovf_not_yet");
        acc(18'h30008, 1'b0, 8'h00); chk(S_DAT, 8'h02, "status_full");
        tx_ready_i = 1'b1;
        acc(18'h30000, 1'b1, 8'h88); tx_q.push_back(8'h88);
        tx_ready_i = 1'b0;
        chk(S_OVF, 8'h00, "ovf_concurrent_pop"); chk(S_FULL, 8'h01, "ovf_still_full");
        chk(S_TXD, 8'h81, "ovf_head_after_pop");
        acc(18'h3000C, 1'b0, 8'h00);
        acc(18'h30000, 1'b1, 8'h99);
        chk(S_OVF, 8'h01, "ovf_dropped");
        en = 1'b0;
        tx_ready_i = 1'b1;
        repeat (8) step();
        tx_ready_i = 1'b0;
        chk(S_TXV, 8'h00, "ovf_drained"); chk(S_FULL, 8'h00, "ovf_not_full");

        // Pause and halt
        acc(18'h00010, 1'b0, 8'h00); chk(S_DAT, 8'hA5, "pause_pre");
        en = 1'b0;
        host_rx(8'h33);
        adr_i = 18'h30000; rwen_i = 1'b0;
        step(); step();
        chk(S_DAT, 8'hA5, "pause_dat_holds");
        acc(18'h30008, 1'b0, 8'h00); chk(S_DAT, 8'h01, "pause_no_pop");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h33, "pause_then_pop");
        acc(18'h30004, 1'b1, 8'h00); chk(S_HALT, 8'h01, "halt_set");
        idle(3);
        chk(S_HALT, 8'h01, "halt_sticky"); chk(S_DAT, 8'h33, "halt_wr_holds_dat");

        // Reset mid-stream
        for (int k = 0; k < 8; k++) host_rx(8'h40 + 8'(k));
        chk(S_RXR, 8'h00, "rx_full_not_ready");
        rx_valid_i = 1'b1; rx_dat_i = 8'hEE;
        step();
        rx_valid_i = 1'b0;
        chk(S_RXR, 8'h00, "rx_full_refuses");
        acc(18'h30000, 1'b1, 8'h66);
        acc(18'h3000C, 1'b0, 8'h00);
        acc(18'h30000, 1'b1, 8'h77);
        acc(18'h00010, 1'b0, 8'h00);
        idle(1);
        chk(S_TXV, 8'h01, "pre_rst_tx_valid"); chk(S_DAT, 8'hA5, "pre_rst_dat");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk(S_RXR, 8'h01, "mid_rst_rx_ready"); chk(S_TXV, 8'h00, "mid_rst_tx_valid");
        chk(S_TXD, 8'h00, "mid_rst_tx_dat"); chk(S_DAT, 8'h00, "mid_rst_dat");
        chk(S_HALT, 8'h00, "mid_rst_halt"); chk(S_FULL, 8'h00, "mid_rst_full");
        acc(18'h30000, 1'b0, 8'h00); chk(S_DAT, 8'h00, "mid_rst_rd_con");
        acc(18'h30008, 1'b0, 8'h00); chk(S_DAT, 8'h00, "mid_rst_status");
        en = 1'b0;
        tx_ready_i = 1'b1;
        repeat (3) step();
        tx_ready_i = 1'b0;
        step(); step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL exp_queue_left: got %0d want 0", exp_q.size());
        end
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL tx_queue_left: got %0d want 0", tx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
